// File: rtl/qspi_seq_pkg.sv
// Shared opcodes, FSM states and command bundle
// for the QSPI flash sequencer.
package qspi_seq_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_SE    = 8'h20;
  localparam logic [7:0] OP_QPP   = 8'h32;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_QREAD = 8'h6B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN_E,
    ST_ERASE,
    ST_POLL_E,
    ST_WREN_P,
    ST_PROG,
    ST_POLL_P,
    ST_READ,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [2:0]  nbytes;
    logic        dir;
    logic [31:0] wdata;
  } cmd_t;

  function automatic cmd_t mk_cmd(
    input logic [7:0]  op,
    input logic [23:0] addr,
    input logic [2:0]  nb,
    input logic        dir,
    input logic [31:0] wd
  );
    cmd_t c;
    c.op     = op;
    c.addr   = addr;
    c.nbytes = nb;
    c.dir    = dir;
    c.wdata  = wd;
    return c;
  endfunction

endpackage

// File: rtl/qspi_flash_sequencer_key_edge.sv
// Per-bit 2-flop synchroniser and falling-edge
// detector; each press gives a one-cycle event.
module key_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_keys_n,
  output logic [W-1:0] o_ev
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  // synchronise keys and keep previous level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_s3 <= '1;
    end else begin
      r_s1 <= i_keys_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_ev = r_s3 & ~r_s2;

endmodule

// File: rtl/qspi_flash_sequencer.sv
// Button-driven QSPI flash sequencer: erase/program
// with status polling, quad read, and a counter.
module qspi_flash_sequencer
  import qspi_seq_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h010000,
  parameter logic [15:0] POLL_MAX   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keys_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [23:0] cmd_addr,
  output logic [2:0]  cmd_nbytes,
  output logic        cmd_dir,
  output logic [31:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        err,
  output logic [5:0]  leds
);

  logic [3:0]  w_ev;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_issued;
  logic        r_err;
  logic [31:0] r_value;
  logic [31:0] r_wdata;
  logic [15:0] r_poll;
  cmd_t        w_cmd;
  logic        w_cmd_act;
  logic        w_idle;
  logic        w_go_wr;
  logic        w_go_rd;
  logic        w_add;
  logic        w_sub;
  logic        w_hs;
  logic        w_done;
  logic        w_wip;
  logic        w_poll_last;
  logic        w_leave;

  key_edge #(.W(4)) u_keys (
    .clk      (clk),
    .rst      (rst),
    .i_keys_n (keys_n),
    .o_ev     (w_ev)
  );

  assign w_idle  = (r_state == ST_IDLE);
  assign w_go_wr = w_idle & w_ev[3];
  assign w_go_rd = w_idle & ~w_ev[3] & w_ev[2];
  assign w_add   = w_idle & ~|w_ev[3:2] & w_ev[1];
  assign w_sub   = w_idle & ~|w_ev[3:1] & w_ev[0];

  assign w_hs        = cmd_valid & cmd_ready;
  assign w_done      = r_issued & rsp_valid;
  assign w_wip       = rsp_rdata[0];
  assign w_poll_last = (r_poll == POLL_MAX - 16'd1);
  assign w_leave     = (w_state_nxt != r_state);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state: advance only on the response
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go_wr)      w_state_nxt = ST_WREN_E;
        else if (w_go_rd) w_state_nxt = ST_READ;
      end
      ST_WREN_E: if (w_done) w_state_nxt = ST_ERASE;
      ST_ERASE:  if (w_done) w_state_nxt = ST_POLL_E;
      ST_POLL_E: begin
        if (w_done) begin
          if (!w_wip)          w_state_nxt = ST_WREN_P;
          else if (w_poll_last) w_state_nxt = ST_ERROR;
        end
      end
      ST_WREN_P: if (w_done) w_state_nxt = ST_PROG;
      ST_PROG:   if (w_done) w_state_nxt = ST_POLL_P;
      ST_POLL_P: begin
        if (w_done) begin
          if (!w_wip)          w_state_nxt = ST_IDLE;
          else if (w_poll_last) w_state_nxt = ST_ERROR;
        end
      end
      ST_READ:   if (w_done) w_state_nxt = ST_IDLE;
      ST_ERROR:  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // outputs: command fields decoded from state
  always_comb begin
    w_cmd     = '0;
    w_cmd_act = 1'b0;
    unique case (r_state)
      ST_WREN_E, ST_WREN_P: begin
        w_cmd     = mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0);
        w_cmd_act = 1'b1;
      end
      ST_ERASE: begin
        w_cmd     = mk_cmd(OP_SE, FLASH_ADDR, 3'd0, 1'b0, 32'h0);
        w_cmd_act = 1'b1;
      end
      ST_POLL_E, ST_POLL_P: begin
        w_cmd     = mk_cmd(OP_RDSR, 24'h0, 3'd1, 1'b1, 32'h0);
        w_cmd_act = 1'b1;
      end
      ST_PROG: begin
        w_cmd     = mk_cmd(OP_QPP, FLASH_ADDR, 3'd4, 1'b0, r_wdata);
        w_cmd_act = 1'b1;
      end
      ST_READ: begin
        w_cmd     = mk_cmd(OP_QREAD, FLASH_ADDR, 3'd4, 1'b1, 32'h0);
        w_cmd_act = 1'b1;
      end
      default: begin
        w_cmd     = '0;
        w_cmd_act = 1'b0;
      end
    endcase
  end

  assign cmd_valid  = w_cmd_act & ~r_issued;
  assign cmd_op     = w_cmd.op;
  assign cmd_addr   = w_cmd.addr;
  assign cmd_nbytes = w_cmd.nbytes;
  assign cmd_dir    = w_cmd.dir;
  assign cmd_wdata  = w_cmd.wdata;
  assign busy       = ~w_idle;
  assign err        = r_err;
  assign leds       = ~r_value[5:0];

  // accepted-command flag; cleared to reissue polls
  always_ff @(posedge clk) begin
    if (rst)                  r_issued <= 1'b0;
    else if (w_leave || w_done) r_issued <= 1'b0;
    else if (w_hs)            r_issued <= 1'b1;
  end

  // poll counter restarts on every state change
  always_ff @(posedge clk) begin
    if (rst)         r_poll <= '0;
    else if (w_leave) r_poll <= '0;
    else if (w_done)  r_poll <= r_poll + 16'd1;
  end

  // value register: read load, add, sub
  always_ff @(posedge clk) begin
    if (rst)
      r_value <= '0;
    else if (r_state == ST_READ && w_done)
      r_value <= rsp_rdata;
    else if (w_add)
      r_value <= r_value + 32'd1;
    else if (w_sub)
      r_value <= r_value - 32'd1;
  end

  // program data snapshot at write start
  always_ff @(posedge clk) begin
    if (rst)         r_wdata <= '0;
    else if (w_go_wr) r_wdata <= r_value;
  end

  // sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst)                    r_err <= 1'b0;
    else if (r_state == ST_ERROR) r_err <= 1'b1;
    else if (w_go_wr || w_go_rd)  r_err <= 1'b0;
  end

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Scoreboard bench: stimulus queues expected commands,
// a monitor checks every handshake against them.
module tb_qspi_flash_sequencer;
  import qspi_seq_pkg::*;

  localparam logic [23:0] FA = 24'h010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keys_n = 4'hF;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [2:0]  cmd_nbytes;
  logic        cmd_dir;
  logic [31:0] cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;
  logic        busy;
  logic        err;
  logic [5:0]  leds;

  int          checks = 0;
  int          errors = 0;
  cmd_t        sb[$];
  bit          wip_q[$];
  logic [31:0] rd_data = 32'h0;

  qspi_flash_sequencer #(
    .FLASH_ADDR (FA),
    .POLL_MAX   (16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_n     (keys_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_nbytes (cmd_nbytes),
    .cmd_dir    (cmd_dir),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .err        (err),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: compare each handshake with the queue
  initial begin : mon
    cmd_t a;
    cmd_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && cmd_valid && cmd_ready) begin
        a = mk_cmd(cmd_op, cmd_addr, cmd_nbytes,
                   cmd_dir, cmd_wdata);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got %h want none", a);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL cmd got %h want %h", a, e);
          end
        end
      end
    end
  end

  // flash model: ready one cycle after valid,
  // response two cycles after the handshake
  initial begin : mdl
    logic [7:0] op;
    bit ab;
    bit w;
    forever begin
      @(negedge clk);
      if (rst || !cmd_valid) continue;
      cmd_ready = 1'b1;
      op = cmd_op;
      @(negedge clk);
      cmd_ready = 1'b0;
      if (rst) continue;
      ab = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (rst) ab = 1'b1;
      end
      if (ab) continue;
      rsp_valid = 1'b1;
      if (op == OP_RDSR) begin
        w = 1'b0;
        if (wip_q.size() > 0) w = wip_q.pop_front();
        rsp_rdata = {31'd0, w};
      end else if (op == OP_QREAD) begin
        rsp_rdata = rd_data;
      end else begin
        rsp_rdata = 32'h0;
      end
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_rdata = 32'h0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    wip_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(logic [3:0] m);
    @(negedge clk);
    keys_n = ~m;
    repeat (3) @(negedge clk);
    keys_n = 4'hF;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(string nm, int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_left"}, sb.size(), 32'd0);
  endtask

  initial begin : stim
    int n;
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_value", dut.r_value, 32'h0);
    chk("rst_leds", {26'd0, leds}, 32'h3F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_op", {24'd0, cmd_op}, 32'd0);

    // add x3, sub x1
    repeat (3) press(4'b0010);
    press(4'b0001);
    chk("addsub_value", dut.r_value, 32'h2);
    chk("addsub_leds", {26'd0, leds}, 32'h3D);

    // underflow
    do_reset();
    press(4'b0001);
    chk("sub_value", dut.r_value, 32'hFFFF_FFFF);
    chk("sub_leds", {26'd0, leds}, 32'h00);

    // load 0x12345678 by a read
    rd_data = 32'h1234_5678;
    sb.push_back(mk_cmd(OP_QREAD, FA, 3'd4, 1'b1, 32'h0));
    press(4'b0100);
    wait_done("rd1", 200);
    chk("rd1_value", dut.r_value, 32'h1234_5678);

    // write with two busy polls during erase
    wip_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    sb.push_back(mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_SE, FA, 3'd0, 1'b0, 32'h0));
    repeat (3)
      sb.push_back(mk_cmd(OP_RDSR, 24'h0, 3'd1, 1'b1, 32'h0));
    sb.push_back(mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_QPP, FA, 3'd4, 1'b0, 32'h1234_5678));
    sb.push_back(mk_cmd(OP_RDSR, 24'h0, 3'd1, 1'b1, 32'h0));
    press(4'b1000);
    wait_done("wr1", 400);
    chk("wr1_err", {31'd0, err}, 32'd0);

    // plain read
    rd_data = 32'hA5A5_A5A5;
    sb.push_back(mk_cmd(OP_QREAD, FA, 3'd4, 1'b1, 32'h0));
    press(4'b0100);
    wait_done("rd2", 200);
    chk("rd2_value", dut.r_value, 32'hA5A5_A5A5);
    chk("rd2_leds", {26'd0, leds}, 32'h1A);

    // poll timeout during erase
    wip_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    sb.push_back(mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_SE, FA, 3'd0, 1'b0, 32'h0));
    repeat (4)
      sb.push_back(mk_cmd(OP_RDSR, 24'h0, 3'd1, 1'b1, 32'h0));
    press(4'b1000);
    wait_done("to", 400);
    repeat (10) @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_extra", sb.size(), 32'd0);
    wip_q.delete();

    // next read clears err
    rd_data = 32'h0000_0C3C;
    sb.push_back(mk_cmd(OP_QREAD, FA, 3'd4, 1'b1, 32'h0));
    press(4'b0100);
    wait_done("rd3", 200);
    chk("rd3_err", {31'd0, err}, 32'd0);
    chk("rd3_value", dut.r_value, 32'h0000_0C3C);

    // write+add together, add while busy,
    // then reset during PROG
    wip_q = '{1'b0};
    sb.push_back(mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_SE, FA, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_RDSR, 24'h0, 3'd1, 1'b1, 32'h0));
    sb.push_back(mk_cmd(OP_WREN, 24'h0, 3'd0, 1'b0, 32'h0));
    sb.push_back(mk_cmd(OP_QPP, FA, 3'd4, 1'b0, 32'h0000_0C3C));
    press(4'b1010);
    press(4'b0010);
    n = 0;
    while (!(cmd_valid && cmd_op == OP_QPP) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("prog_seen", {31'd0, cmd_valid}, 32'd1);
    chk("prog_value", dut.r_value, 32'h0000_0C3C);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, cmd_valid}, 32'd0);
    chk("abort_value", dut.r_value, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_leds", {26'd0, leds}, 32'h3F);
    chk("abort_left", sb.size(), 32'd1);
    sb.delete();
    wip_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_flash_sequencer.md
QSPI_FLASH_SEQUENCER -- requirements
Module: qspi_flash_sequencer

Interface
REQ-001 Parameter FLASH_ADDR, 24'h010000, sector-aligned flash address used by every operation.
REQ-002 Parameter POLL_MAX, 16'd1000, maximum status polls per erase/program before error.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 keys_n  in  4  active-low, asynchronous buttons: [3] write, [2] read, [1] add, [0] sub.
REQ-006 cmd_valid  out  1  command request to QSPI master.
REQ-007 cmd_ready  in  1  master accepts command when cmd_valid&&cmd_ready.
REQ-008 cmd_op  out  8  flash opcode.
REQ-009 cmd_addr  out  24  flash address; FLASH_ADDR for erase/program/read, 0 otherwise.
REQ-010 cmd_nbytes  out  3  data bytes, 0..4.
REQ-011 cmd_dir  out  1  1 = read data from flash, 0 = write/none.
REQ-012 cmd_wdata  out  32  program data, MSB byte first.
REQ-013 rsp_valid  in  1  one-cycle pulse, exactly one per accepted command, at its completion.
REQ-014 rsp_rdata  in  32  read data, valid with rsp_valid; status byte in [7:0].
REQ-015 busy  out  1  high whenever state != IDLE.
REQ-016 err  out  1  sticky poll-timeout flag.
REQ-017 leds  out  6  active-low display: leds = ~value[5:0].

Function
REQ-018 Each key passes a 2-flop synchroniser; a press SHALL be a 1->0 transition of the synchronised level, yielding one single-cycle event.
REQ-019 Events SHALL be acted on only in IDLE; events during busy SHALL be dropped, not queued.
REQ-020 Simultaneous events in IDLE SHALL resolve by priority write > read > add > sub; losers dropped.
REQ-021 add/sub SHALL update the 32-bit value register +1/-1 modulo 2^32 the cycle after the event (0xFFFFFFFF+1 = 0, 0-1 = 0xFFFFFFFF).
REQ-022 FSM states: IDLE, WREN_E, ERASE, POLL_E, WREN_P, PROG, POLL_P, READ, ERROR.
REQ-023 Every non-IDLE/ERROR state SHALL hold cmd_valid and stable cmd_* fields until handshake, drop cmd_valid the cycle after, then wait for rsp_valid before transitioning.
REQ-024 Write: IDLE -> WREN_E (0x06, 0 bytes) -> ERASE (0x20, addr) -> POLL_E -> WREN_P (0x06) -> PROG (0x32, addr, 4 bytes, value) -> POLL_P -> IDLE.
REQ-025 POLL_x SHALL issue RDSR (0x05, 1 byte, dir=1); rsp_rdata[0]=1 reissues RDSR, 0 advances.
REQ-026 Poll counter SHALL reset on entering each POLL_x; reaching POLL_MAX responses with WIP=1 SHALL go to ERROR.
REQ-027 Read: IDLE -> READ (0x6B, addr, 4 bytes, dir=1) -> IDLE, loading value <= rsp_rdata on rsp_valid.
REQ-028 PROG cmd_wdata SHALL be value captured at write-event time; add/sub cannot alter it.
REQ-029 ERROR SHALL set err, then return to IDLE next cycle; err clears when the next write or read starts.
REQ-030 rsp_valid in IDLE or before handshake SHALL be ignored.

Reset
REQ-031 rst SHALL force state=IDLE, value=0, err=0, cmd_valid=0, cmd_op/addr/nbytes/dir/wdata=0, poll counter=0, synchroniser flops=1 (released); leds=6'h3F.
REQ-032 rst mid-operation SHALL abort immediately with cmd_valid low next cycle; no completion of the pending command is awaited.

Structure
REQ-033 Package qspi_seq_pkg SHALL hold opcode constants (WREN, SE, QPP, RDSR, QREAD) and the state enumeration.
REQ-034 Sub-module key_edge (synchroniser plus falling-edge detector, per key bit) SHALL be instantiated once with 4-bit width.

Verification
REQ-035 Reset, then add x3, sub x1 -> value=2, leds=6'b111101, no cmd_valid.
REQ-036 Reset, sub x1 -> value=0xFFFFFFFF, leds=6'b000000.
REQ-037 value=0x12345678, write; model answers RDSR with WIP=1 twice then 0 -> opcode sequence 06,20,05,05,05,06,32,05; PROG wdata=0x12345678; busy falls after final response.
REQ-038 Read with model rdata=0xA5A5A5A5 -> one 0x6B command at FLASH_ADDR, value=0xA5A5A5A5, leds=6'b011010.
REQ-039 POLL_MAX=4, model always WIP=1 during erase -> exactly 4 RDSR, err=1, state IDLE, no PROG issued; next read clears err.
REQ-040 Write and add pressed same cycle, then add during busy -> only write runs, value unchanged; rst asserted in PROG -> cmd_valid=0 next cycle, value=0.
